mc_controller_ext: RTL and testbench
====================================

Name: mc_controller_ext

Overview:
Parametrised next-generation multicycle MIPS controller: Moore main FSM plus combinational ALU decoder. It drives the multicycle datapath's enables and muxes.
It extends the base lw/sw/R-type/beq set with addi, andi, ori, bne and j, each enabled by parameter. It adds an illegal-instruction flag, a retire strobe and a state debug port.
It sits between the instruction register (op/funct) and the datapath; the ALU returns zero.

Parameters:
ALUCW, 3, alucontrol width; codes occupy bits [2:0], upper bits are driven 0
EN_IMM, 1, enables addi/andi/ori
EN_BNE, 1, enables bne
EN_JUMP, 1, enables j

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
op  in  6  instr[31:26]
funct  in  6  instr[5:0]
zero  in  1  ALU zero flag
pcen  out  1  PC register enable
memwrite  out  1  memory write
irwrite  out  1  instruction register write
regwrite  out  1  register file write
alusrca  out  1  0=PC, 1=A
iord  out  1  0=PC, 1=ALUOut address
memtoreg  out  1  0=ALUOut, 1=Data
regdst  out  1  0=rt, 1=rd
zeroext  out  1  1=zero-extend immediate (andi/ori)
alusrcb  out  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
pcsrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target
alucontrol  out  ALUCW  ALU operation
illegal  out  1  one-cycle pulse in DECODE on unsupported op/funct
retire  out  1  high in the final state of each instruction
state  out  4  current state encoding (debug)

Behaviour:
- Opcodes: lw 100011, sw 101011, R 000000, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, j 000010.
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, BNEEX 9, ADDIEX 10, IWB 11, JEX 12, ANDIEX 13, ORIEX 14.
- Transitions:
  - FETCH->DECODE.
  - DECODE: lw/sw->MEMADR; R->RTYPEEX; beq->BEQEX; bne->BNEEX; addi->ADDIEX; andi->ANDIEX; ori->ORIEX; j->JEX.
  - DECODE, disabled or unknown op, or R-type with unknown funct: ->FETCH with illegal=1.
  - MEMADR: lw->MEMRD, sw->MEMWR.
  - MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX/ANDIEX/ORIEX->IWB.
  - MEMWB, MEMWR, RTYPEWB, IWB, BEQEX, BNEEX, JEX: ->FETCH.
- Outputs are Moore; every output not listed for a state is 0:
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR/ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - BNEEX: same as BEQEX but branchne=1 instead of branch.
  - ANDIEX/ORIEX: alusrca=1, alusrcb=10, zeroext=1, aluop=11.
  - IWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- pcen = pcwrite | (branch & zero) | (branchne & ~zero), combinational.
- retire=1 in MEMWB, MEMWR, RTYPEWB, IWB, BEQEX, BNEEX, JEX.
- ALU decoder:
  - aluop 00 -> 010; aluop 01 -> 110.
  - aluop 10 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
  - aluop 11 -> 000 in ANDIEX, 001 in ORIEX.
  - Undefined -> 000.
- Reset: while reset=1, pcen/memwrite/irwrite/regwrite/illegal/retire are forced to 0. The first edge with reset=1 loads FETCH. Reset asserted mid-instruction aborts that instruction; no write occurs during the reset cycle.
- Cycle counts: lw 5, sw 4, R 4, addi/andi/ori 4, beq/bne 3, j 3, illegal 2.

Decomposition:
- Shared package mc_pkg: opcode and funct constants, state encoding, aluop codes, alucontrol codes. The state encoding and alucontrol codes are shared with the datapath and the bench.
- One natural sub-module: mc_aludec (aluop, funct, state flag -> alucontrol). The FSM stays in the top module.

Test Plan:
- Reset held 2 cycles, then op=100011 (lw) -> states 0,1,2,3,4; regwrite=1 and memtoreg=1 only in state 4; retire=1 at state 4; pcen=1 at state 0 only.
- op=000000, funct=101010 (slt) -> alucontrol=111 in state 6, regdst=1/regwrite=1 in state 7; funct=111111 -> illegal pulse in DECODE, back to FETCH, no regwrite.
- op=000100 (beq) with zero=1 -> pcen=1, pcsrc=01 in state 8; with zero=0 -> pcen=0. Then op=000101 (bne) -> opposite pcen polarity.
- op=001101 (ori) -> state 14 with zeroext=1 and alucontrol=001, then IWB with regwrite=1, regdst=0. Rebuild with EN_IMM=0 -> same op gives illegal=1 and returns to FETCH.
- op=000010 (j) -> state 12: pcsrc=10, pcen=1, 3 cycles total. Reset asserted in MEMRD of an lw -> next state 0, and regwrite is never 1.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller, its datapath and the bench.
package mc_pkg;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_BNEEX   = 4'd9;
  localparam logic [3:0] S_ADDIEX  = 4'd10;
  localparam logic [3:0] S_IWB     = 4'd11;
  localparam logic [3:0] S_JEX     = 4'd12;
  localparam logic [3:0] S_ANDIEX  = 4'd13;
  localparam logic [3:0] S_ORIEX   = 4'd14;

  localparam logic [1:0] AOP_ADD = 2'b00;
  localparam logic [1:0] AOP_SUB = 2'b01;
  localparam logic [1:0] AOP_FN  = 2'b10;
  localparam logic [1:0] AOP_LOG = 2'b11;

  localparam logic [2:0] AC_AND = 3'b000;
  localparam logic [2:0] AC_OR  = 3'b001;
  localparam logic [2:0] AC_ADD = 3'b010;
  localparam logic [2:0] AC_SUB = 3'b110;
  localparam logic [2:0] AC_SLT = 3'b111;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       branchne;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       zeroext;
    logic       retire;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) || (f == F_SLT);
  endfunction
endpackage

// File: rtl/mc_controller_ext_if.sv
// Controller <-> datapath/instruction-register bundle; master is the controller side.
interface mc_controller_ext_if #(parameter int ALUCW = 3);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             pcen, memwrite, irwrite, regwrite;
  logic             alusrca, iord, memtoreg, regdst, zeroext;
  logic [1:0]       alusrcb, pcsrc;
  logic [ALUCW-1:0] alucontrol;
  logic             illegal, retire;
  logic [3:0]       state;

  modport master (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
           zeroext, alusrcb, pcsrc, alucontrol, illegal, retire, state
  );
  modport slave (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
           zeroext, alusrcb, pcsrc, alucontrol, illegal, retire, state
  );
endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: aluop/funct to 3-bit ALU operation; ori selects OR for the logical-immediate op.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  input  logic       ori,
  output logic [2:0] alucontrol
);
  always_comb begin
    alucontrol = AC_AND;
    case (aluop)
      AOP_ADD: alucontrol = AC_ADD;
      AOP_SUB: alucontrol = AC_SUB;
      AOP_FN: begin
        case (funct)
          F_ADD:   alucontrol = AC_ADD;
          F_SUB:   alucontrol = AC_SUB;
          F_AND:   alucontrol = AC_AND;
          F_OR:    alucontrol = AC_OR;
          F_SLT:   alucontrol = AC_SLT;
          default: alucontrol = AC_AND;
        endcase
      end
      AOP_LOG: alucontrol = ori ? AC_OR : AC_AND;
      default: alucontrol = AC_AND;
    endcase
  end
endmodule

// File: rtl/mc_controller_ext.sv
// Multicycle MIPS controller: Moore main FSM with optional imm/bne/j support, plus ALU decoder.
module mc_controller_ext
  import mc_pkg::*;
#(
  parameter int ALUCW   = 3,
  parameter bit EN_IMM  = 1'b1,
  parameter bit EN_BNE  = 1'b1,
  parameter bit EN_JUMP = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  mc_controller_ext_if.master bus
);
  logic [3:0]       state, nxt, dec_nxt;
  logic             bad;
  ctrl_t            c;
  logic [2:0]       ac;
  logic [ALUCW-1:0] ac_w;

  always_comb begin
    dec_nxt = S_FETCH;
    bad     = 1'b0;
    case (bus.op)
      OP_LW, OP_SW: dec_nxt = S_MEMADR;
      OP_R:    if (funct_ok(bus.funct)) dec_nxt = S_RTYPEEX; else bad = 1'b1;
      OP_BEQ:  dec_nxt = S_BEQEX;
      OP_BNE:  if (EN_BNE)  dec_nxt = S_BNEEX;  else bad = 1'b1;
      OP_ADDI: if (EN_IMM)  dec_nxt = S_ADDIEX; else bad = 1'b1;
      OP_ANDI: if (EN_IMM)  dec_nxt = S_ANDIEX; else bad = 1'b1;
      OP_ORI:  if (EN_IMM)  dec_nxt = S_ORIEX;  else bad = 1'b1;
      OP_J:    if (EN_JUMP) dec_nxt = S_JEX;    else bad = 1'b1;
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:   nxt = S_DECODE;
      S_DECODE:  nxt = dec_nxt;
      S_MEMADR:  nxt = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   nxt = S_MEMWB;
      S_RTYPEEX: nxt = S_RTYPEWB;
      S_ADDIEX, S_ANDIEX, S_ORIEX: nxt = S_IWB;
      default:   nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= nxt;
  end

  always_comb begin
    c = '0;
    case (state)
      S_FETCH:  begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:  c.iord = 1'b1;
      S_MEMWB:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; c.retire = 1'b1; end
      S_MEMWR:  begin c.iord = 1'b1; c.memwrite = 1'b1; c.retire = 1'b1; end
      S_RTYPEEX: begin c.alusrca = 1'b1; c.aluop = AOP_FN; end
      S_RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; c.retire = 1'b1; end
      S_BEQEX, S_BNEEX: begin
        c.alusrca = 1'b1; c.aluop = AOP_SUB; c.pcsrc = 2'b01; c.retire = 1'b1;
        c.branch = (state == S_BEQEX); c.branchne = (state == S_BNEEX);
      end
      S_ANDIEX, S_ORIEX: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.zeroext = 1'b1; c.aluop = AOP_LOG;
      end
      S_IWB:    begin c.regwrite = 1'b1; c.retire = 1'b1; end
      S_JEX:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; c.retire = 1'b1; end
      default:  c = '0;
    endcase
  end

  mc_aludec u_aludec (
    .aluop      (c.aluop),
    .funct      (bus.funct),
    .ori        (state == S_ORIEX),
    .alucontrol (ac)
  );

  always_comb begin
    ac_w      = '0;
    ac_w[2:0] = ac;
  end

  // State may still point mid-instruction while reset is held, so every
  // side-effecting strobe is gated by reset directly.
  assign bus.pcen       = ~reset & (c.pcwrite | (c.branch & bus.zero) | (c.branchne & ~bus.zero));
  assign bus.memwrite   = ~reset & c.memwrite;
  assign bus.irwrite    = ~reset & c.irwrite;
  assign bus.regwrite   = ~reset & c.regwrite;
  assign bus.illegal    = ~reset & (state == S_DECODE) & bad;
  assign bus.retire     = ~reset & c.retire;
  assign bus.alusrca    = c.alusrca;
  assign bus.iord       = c.iord;
  assign bus.memtoreg   = c.memtoreg;
  assign bus.regdst     = c.regdst;
  assign bus.zeroext    = c.zeroext;
  assign bus.alusrcb    = c.alusrcb;
  assign bus.pcsrc      = c.pcsrc;
  assign bus.alucontrol = ac_w;
  assign bus.state      = state;
endmodule

// File: tb/tb_mc_controller_ext.sv
// Scoreboard bench for mc_controller_ext: per-cycle expected state/outputs queued per instruction.
module tb_mc_controller_ext;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   nchk = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  mc_controller_ext_if #(.ALUCW(3)) bus  ();
  mc_controller_ext_if #(.ALUCW(3)) bus2 ();

  mc_controller_ext #(.ALUCW(3), .EN_IMM(1'b1), .EN_BNE(1'b1), .EN_JUMP(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  mc_controller_ext #(.ALUCW(3), .EN_IMM(1'b0), .EN_BNE(1'b1), .EN_JUMP(1'b1)) dut_noimm (
    .clk(clk), .reset(reset), .bus(bus2));

  typedef struct {
    logic [3:0]  st;
    logic [17:0] o;
  } exp_t;
  exp_t sbq[$];

  logic [17:0] outv;
  assign outv = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.alusrca, bus.iord,
                 bus.memtoreg, bus.regdst, bus.zeroext, bus.alusrcb, bus.pcsrc,
                 bus.alucontrol[2:0], bus.illegal, bus.retire};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic unsupported(input logic [5:0] op, input logic [5:0] f);
    case (op)
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J: return 1'b0;
      OP_R: return !(f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                     f == 6'b100101 || f == 6'b101010);
      default: return 1'b1;
    endcase
  endfunction

  // Reference output table, written from the per-state control list.
  function automatic logic [17:0] exp_out(input logic [3:0] st, input logic [5:0] op,
                                          input logic [5:0] f, input logic zero);
    logic pcen, mw, irw, rw, asa, iord, m2r, rd, zx, ill, ret;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    {pcen, mw, irw, rw, asa, iord, m2r, rd, zx, ill, ret} = '0;
    sb = 2'b00; ps = 2'b00; ac = 3'b010;
    case (st)
      4'd0:  begin irw = 1; pcen = 1; sb = 2'b01; end
      4'd1:  begin sb = 2'b11; ill = unsupported(op, f); end
      4'd2, 4'd10: begin asa = 1; sb = 2'b10; end
      4'd3:  iord = 1;
      4'd4:  begin m2r = 1; rw = 1; ret = 1; end
      4'd5:  begin iord = 1; mw = 1; ret = 1; end
      4'd6:  begin
        asa = 1;
        case (f)
          6'b100000: ac = 3'b010;
          6'b100010: ac = 3'b110;
          6'b100100: ac = 3'b000;
          6'b100101: ac = 3'b001;
          6'b101010: ac = 3'b111;
          default:   ac = 3'b000;
        endcase
      end
      4'd7:  begin rd = 1; rw = 1; ret = 1; end
      4'd8:  begin asa = 1; ac = 3'b110; ps = 2'b01; pcen = zero;  ret = 1; end
      4'd9:  begin asa = 1; ac = 3'b110; ps = 2'b01; pcen = ~zero; ret = 1; end
      4'd11: begin rw = 1; ret = 1; end
      4'd12: begin ps = 2'b10; pcen = 1; ret = 1; end
      4'd13: begin asa = 1; sb = 2'b10; zx = 1; ac = 3'b000; end
      4'd14: begin asa = 1; sb = 2'b10; zx = 1; ac = 3'b001; end
      default: ;
    endcase
    return {pcen, mw, irw, rw, asa, iord, m2r, rd, zx, sb, ps, ac, ill, ret};
  endfunction

  // Called at a negedge with the DUT in FETCH; leaves it at the negedge after the last state.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] f,
                           input logic zero, input logic [19:0] seq, input int n);
    exp_t e;
    bus.op = op; bus.funct = f; bus.zero = zero;
    for (int i = 0; i < n; i++) begin
      e.st = seq[4*i +: 4];
      e.o  = exp_out(e.st, op, f, zero);
      sbq.push_back(e);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      #1;
      chk($sformatf("%s st s%0d", name, e.st), {28'd0, bus.state}, {28'd0, e.st});
      chk($sformatf("%s out s%0d", name, e.st), {14'd0, outv}, {14'd0, e.o});
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.op = OP_LW; bus.funct = 6'd0; bus.zero = 1'b0;
    bus2.op = OP_R; bus2.funct = F_ADD; bus2.zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst state", {28'd0, bus.state}, 32'd0);
    chk("rst strobes", {26'd0, bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite,
                        bus.illegal, bus.retire}, 32'd0);
    reset = 1'b0;

    run_instr("lw",   OP_LW,   6'd0,  1'b0, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 5);
    run_instr("sw",   OP_SW,   6'd0,  1'b0, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 4);
    run_instr("slt",  OP_R,    F_SLT, 1'b0, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 4);
    run_instr("sub",  OP_R,    F_SUB, 1'b1, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 4);
    run_instr("or",   OP_R,    F_OR,  1'b0, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 4);
    run_instr("badfn", OP_R, 6'b111111, 1'b0, {12'd0, 4'd1, 4'd0}, 2);
    run_instr("beq1", OP_BEQ,  6'd0,  1'b1, {8'd0, 4'd8, 4'd1, 4'd0}, 3);
    run_instr("beq0", OP_BEQ,  6'd0,  1'b0, {8'd0, 4'd8, 4'd1, 4'd0}, 3);
    run_instr("bne1", OP_BNE,  6'd0,  1'b1, {8'd0, 4'd9, 4'd1, 4'd0}, 3);
    run_instr("bne0", OP_BNE,  6'd0,  1'b0, {8'd0, 4'd9, 4'd1, 4'd0}, 3);
    run_instr("addi", OP_ADDI, 6'd0,  1'b0, {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}, 4);
    run_instr("andi", OP_ANDI, 6'd0,  1'b0, {4'd0, 4'd11, 4'd13, 4'd1, 4'd0}, 4);
    run_instr("ori",  OP_ORI,  6'd0,  1'b0, {4'd0, 4'd11, 4'd14, 4'd1, 4'd0}, 4);
    run_instr("j",    OP_J,    6'd0,  1'b1, {8'd0, 4'd12, 4'd1, 4'd0}, 3);
    run_instr("badop", 6'b111111, 6'd0, 1'b0, {12'd0, 4'd1, 4'd0}, 2);

    // Abort an lw in MEMRD: reset there must suppress the MEMWB write.
    run_instr("lwab", OP_LW, 6'd0, 1'b0, {8'd0, 4'd2, 4'd1, 4'd0}, 3);
    #1;
    chk("abort at memrd", {28'd0, bus.state}, {28'd0, S_MEMRD});
    reset = 1'b1;
    #1;
    chk("abort rw0", {31'd0, bus.regwrite}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort state", {28'd0, bus.state}, 32'd0);
    chk("abort rw1", {31'd0, bus.regwrite}, 32'd0);
    reset = 1'b0;
    run_instr("post", OP_R, F_ADD, 1'b0, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 4);

    // EN_IMM=0 build: ori must be flagged illegal in DECODE.
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus2.op = OP_ORI;
    #1;
    chk("noimm fetch", {28'd0, bus2.state}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("noimm decode", {28'd0, bus2.state}, 32'd1);
    chk("noimm illegal", {31'd0, bus2.illegal}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("noimm back", {28'd0, bus2.state}, 32'd0);
    chk("noimm rw", {31'd0, bus2.regwrite}, 32'd0);
    chk("noimm ill off", {31'd0, bus2.illegal}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
